// File: rtl/fetch_pkg.sv
// Shared types, constants and helpers for the fetch sequencer and its prefetch FIFO.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam int PC_INC     = 4;
    localparam int DEF_PC_W   = 11;
    localparam int DEF_INST_W = 32;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, inst} with occupancy count and synchronous flush.
// Head outputs come straight from storage registers.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_W   = DEF_PC_W,
    parameter int INST_W = DEF_INST_W,
    parameter int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [PC_W-1:0]   push_pc,
    input  logic [INST_W-1:0] push_inst,
    input  logic              pop,
    output logic              head_valid,
    output logic [PC_W-1:0]   head_pc,
    output logic [INST_W-1:0] head_inst,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PC_W-1:0]   pc_mem_q   [DEPTH];
    logic [PC_W-1:0]   pc_mem_d   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Pointer, count and storage update; flush discards everything including a same-cycle push.
    always_comb begin
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        do_pop     = pop && (count_q != {CNT_W{1'b0}});
        do_push    = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push) begin
                pc_mem_d[wr_ptr_q]   = push_pc;
                inst_mem_d[wr_ptr_q] = push_inst;
                wr_ptr_d             = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= {PC_W{1'b0}};
                inst_mem_q[i] <= {INST_W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign head_valid = (count_q != {CNT_W{1'b0}});
    assign head_pc    = pc_mem_q[rd_ptr_q];
    assign head_inst  = inst_mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues one fetch per cycle, drops redirect-stale
// responses and feeds decode through a prefetch FIFO. FETCH_PERF_CNT_EN adds perf counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              PC_W       = DEF_PC_W,
    parameter int              INST_W     = DEF_INST_W,
    parameter logic [PC_W-1:0] RESET_PC   = {PC_W{1'b0}},
    parameter int              FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic              busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam int OCC_W = CNT_W + 2;

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic              epoch_q, epoch_d;
    logic              imem_en_q, imem_en_d;
    logic [PC_W-1:0]   imem_addr_q, imem_addr_d;
    logic              s1_epoch_q, s1_epoch_d;
    logic              s2_valid_q, s2_valid_d;
    logic              s2_epoch_q, s2_epoch_d;
    logic [PC_W-1:0]   s2_pc_q, s2_pc_d;
    logic              issue;
    logic              pop;
    logic              push;
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_valid;

    assign pop  = fifo_valid && out_ready;
    assign push = s2_valid_q && (s2_epoch_q == epoch_q) && !redirect_valid;

    // Stage 1 of the in-flight pipe is the registered request itself (imem_en_q/imem_addr_q).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start && !halt) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        occ   = OCC_W'(fifo_count) + OCC_W'(imem_en_q) + OCC_W'(s2_valid_q) - OCC_W'(pop);
        issue = (state_d == ST_RUN) && !redirect_valid && (occ < OCC_W'(FIFO_DEPTH));

        fetch_pc_d  = fetch_pc_q;
        imem_addr_d = imem_addr_q;
        s1_epoch_d  = s1_epoch_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~(PC_W'(3));
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_W'(PC_INC);
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
        if (issue) begin
            imem_addr_d = fetch_pc_q;
            s1_epoch_d  = epoch_q;
        end else begin
            imem_addr_d = imem_addr_q;
            s1_epoch_d  = s1_epoch_q;
        end

        imem_en_d  = issue;
        epoch_d    = epoch_q ^ redirect_valid;
        s2_valid_d = imem_en_q;
        s2_epoch_d = s1_epoch_q;
        s2_pc_d    = imem_addr_q;
    end

    // Control state, PC and in-flight pipe registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            epoch_q     <= 1'b0;
            imem_en_q   <= 1'b0;
            imem_addr_q <= RESET_PC;
            s1_epoch_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_epoch_q  <= 1'b0;
            s2_pc_q     <= {PC_W{1'b0}};
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            epoch_q     <= epoch_d;
            imem_en_q   <= imem_en_d;
            imem_addr_q <= imem_addr_d;
            s1_epoch_q  <= s1_epoch_d;
            s2_valid_q  <= s2_valid_d;
            s2_epoch_q  <= s2_epoch_d;
            s2_pc_q     <= s2_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .PC_W   (PC_W),
        .INST_W (INST_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_pc    (s2_pc_q),
        .push_inst  (imem_data),
        .pop        (pop),
        .head_valid (fifo_valid),
        .head_pc    (out_pc),
        .head_inst  (out_inst),
        .count      (fifo_count)
    );

    assign imem_en   = imem_en_q;
    assign imem_addr = imem_addr_q;
    assign out_valid = fifo_valid;
    assign busy      = (state_q == ST_RUN) || imem_en_q || s2_valid_q ||
                       (fifo_count != {CNT_W{1'b0}});

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating handshake and stall counters.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (pop && (perf_fetched_q != 32'hFFFF_FFFF)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end else begin
            perf_fetched_d = perf_fetched_q;
        end
        if (fifo_valid && !out_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_stall_d = perf_stall_q;
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched_q <= 32'd0;
            perf_stall_q   <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`else
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory returns word = address, outputs checked
// against hand-derived PC sequences and cycle positions.
module tb_fetch_sequencer;

    localparam int PC_W   = 11;
    localparam int INST_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              halt;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              imem_en;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_data = 32'd0;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc;
    logic              busy;

    int              n_vec   = 0;
    int              n_err   = 0;
    int              issued  = 0;
    int              popped  = 0;
    bit              occ_chk = 1'b0;
    logic [PC_W-1:0] exp_pc  = 11'h000;

    fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Synchronous memory: word = address, poison when not enabled.
    always @(posedge clk) begin
        imem_data <= imem_en ? {21'd0, imem_addr} : 32'hDEAD_BEEF;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observe the current cycle (handshake scoreboard, occupancy), then advance one edge.
    task automatic step();
        int occ;
        if (imem_en) issued++;
        occ = issued - popped;
        if (occ_chk) chk_eq("occ_le_depth", {31'd0, (occ <= 4)}, 32'd1);
        if (out_valid && out_ready) begin
            chk_eq("out_pc", {21'd0, out_pc}, {21'd0, exp_pc});
            chk_eq("out_inst", out_inst, {21'd0, exp_pc});
            exp_pc = exp_pc + 11'd4;
            popped++;
        end
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_imem_en"}, {31'd0, imem_en}, 32'd0);
        chk_eq({tag, "_imem_addr"}, {21'd0, imem_addr}, 32'd0);
        chk_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk_eq({tag, "_out_inst"}, out_inst, 32'd0);
        chk_eq({tag, "_out_pc"}, {21'd0, out_pc}, 32'd0);
        chk_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic redirect_to(input logic [PC_W-1:0] target, input logic [PC_W-1:0] first);
        chk_eq("redir_inflight", {31'd0, imem_en}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
        exp_pc         = first;
        for (int i = 0; i < 3; i++) begin
            chk_eq("redir_gap", {31'd0, out_valid}, 32'd0);
            step();
        end
        chk_eq("redir_first_valid", {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 11'h000;
        out_ready      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Cycle 0: reset state, then start.
        chk_reset_outputs("reset");
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        chk_eq("c1_imem_en", {31'd0, imem_en}, 32'd1);
        chk_eq("c1_imem_addr", {21'd0, imem_addr}, 32'd0);
        chk_eq("c1_busy", {31'd0, busy}, 32'd1);
        step();
        chk_eq("c2_imem_addr", {21'd0, imem_addr}, 32'd4);
        chk_eq("c2_out_valid", {31'd0, out_valid}, 32'd0);
        step();
        for (int i = 0; i < 8; i++) begin
            chk_eq("stream_nogap", {31'd0, out_valid}, 32'd1);
            step();
        end

        // Backpressure for 10 cycles.
        occ_chk   = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk_eq("stall_noissue", {31'd0, imem_en}, 32'd0);
        chk_eq("stall_occ", issued - popped, 32'd4);
        chk_eq("stall_valid", {31'd0, out_valid}, 32'd1);
        chk_eq("stall_hold_pc", {21'd0, out_pc}, {21'd0, exp_pc});
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        occ_chk = 1'b0;

        // Redirect with fetches in flight, then to the top of memory to exercise wrap.
        redirect_to(11'h101, 11'h100);
        for (int i = 0; i < 4; i++) step();
        chk_eq("redir_seq_next", {21'd0, exp_pc}, 32'h110);
        redirect_to(11'h7FC, 11'h7FC);
        for (int i = 0; i < 4; i++) step();
        chk_eq("wrap_seq_next", {21'd0, exp_pc}, 32'h00C);

        // Halt: drain, go idle, resume sequentially.
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk_eq("halt_noissue", {31'd0, imem_en}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (busy) step();
        end
        chk_eq("halt_busy_low", {31'd0, busy}, 32'd0);
        chk_eq("halt_empty", {31'd0, out_valid}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_eq("resume_en", {31'd0, imem_en}, 32'd1);
        chk_eq("resume_addr", {21'd0, imem_addr}, {21'd0, exp_pc});
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            chk_eq("resume_valid", {31'd0, out_valid}, 32'd1);
            step();
        end

        // One-cycle reset mid-stream.
        rst_n     = 1'b0;
        out_ready = 1'b0;
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        chk_reset_outputs("midrst");
        for (int i = 0; i < 3; i++) begin
            chk_eq("midrst_late_ignored", {31'd0, out_valid}, 32'd0);
            step();
        end
        exp_pc = 11'h000;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk_eq("restart_addr", {21'd0, imem_addr}, 32'd0);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            chk_eq("restart_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        chk_eq("restart_seq_next", {21'd0, exp_pc}, 32'h010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller that drives the synchronous instruction memory and owns the program counter. It issues one word-aligned fetch per cycle and discards fetches made stale by a redirect. Fetched words go into a small prefetch FIFO, which delivers {pc, inst} to decode over a valid/ready handshake. It sits between the branch/halt control logic and the instruction memory, replacing free-running `PC+4` sequencing.

## Interface
- `PC_W`, 11: PC / memory address width.
- `INST_W`, 32: instruction width.
- `RESET_PC`, 0: PC loaded on reset; low 2 bits must be 0.
- `FIFO_DEPTH`, 4: prefetch FIFO entries. Must be ≥3 for full throughput; legal range 2..16.

- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin/resume fetching (IDLE/HALTED → RUN).
- `halt`  in  1  stop issuing new fetches.
- `redirect_valid`  in  1  PC redirect request (branch/jump).
- `redirect_pc`  in  PC_W  redirect target; bits [1:0] forced to 0.
- `imem_en`  out  1  fetch request, registered.
- `imem_addr`  out  PC_W  fetch address, registered.
- `imem_data`  in  INST_W  memory read data, valid the cycle after the memory samples `imem_en`/`imem_addr`.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  decode accepts head.
- `out_inst`  out  INST_W  head instruction.
- `out_pc`  out  PC_W  head PC.
- `busy`  out  1  any fetch in flight or FIFO non-empty, or state RUN.

## Operation
- States:
  - IDLE (after reset).
  - RUN.
  - HALTED.
- Transitions:
  - IDLE/HALTED → RUN on `start & !halt`.
  - RUN → HALTED on `halt`.
  - `halt` wins over `start` in the same cycle.
- Reset values:
  - `imem_en=0`, `imem_addr=RESET_PC`.
  - `out_valid=0`, `out_inst=0`, `out_pc=0`, `busy=0`.
  - `fetch_pc=RESET_PC`, FIFO empty, in-flight pipe cleared, epoch=0.
- Issue rule, evaluated each edge:
  - Issue when state is RUN, no redirect this cycle, and `fifo_count + inflight − pop < FIFO_DEPTH`.
  - `inflight` is 0..2 and `pop = out_valid & out_ready`.
  - On issue: `imem_en=1`, `imem_addr=fetch_pc`, `fetch_pc += 4` modulo 2^PC_W (0x7FC wraps to 0x000).
  - When not issuing, `imem_en=0` and `imem_addr` holds.
- In-flight tracking:
  - A 2-stage shift pipe carries {valid, epoch, pc} for each issued fetch.
  - At stage-2 the response is written to the FIFO with `imem_data` only if its epoch equals the current epoch; otherwise it is dropped.
- Redirect:
  - `fetch_pc ← redirect_pc & ~3`.
  - Epoch toggles.
  - FIFO is flushed at the same edge, including a head being popped that cycle; the pop still counts as delivered.
  - No issue that cycle; issue resumes the next cycle from the new PC if in RUN.
  - A redirect during IDLE/HALTED updates the PC and flushes, with no state change.
- Halt:
  - Issuing stops; in-flight responses are still enqueued.
  - The FIFO keeps draining.
  - `busy` falls once the FIFO is empty and nothing is in flight.
- Simultaneous FIFO push and pop when full is legal; count is unchanged.

## Timing
- Cycle n is the period after edge n.
- `start` high in cycle 0 → `imem_en=1`, `imem_addr=RESET_PC` in cycle 1.
- Memory samples at edge 2, so `imem_data` is valid in cycle 2 and the FIFO writes at edge 3.
- First `out_valid` in cycle 3. Fetch-to-output latency: 2 cycles after request.
- Throughput is 1 instruction/cycle with `out_ready` held high and `FIFO_DEPTH ≥ 3`.
- `out_*` are driven from FIFO registers, with no combinational path from `imem_data`.
- `out_inst`/`out_pc` hold while `out_valid & !out_ready`.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds outputs `perf_fetched` (32) and `perf_stall` (32).
  - `perf_fetched` counts accepted handshakes.
  - `perf_stall` counts cycles with `out_valid & !out_ready`.
  - Both counters saturate at all-ones and are zeroed by reset.
- `FETCH_PERF_CNT_EN` undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `fetch_pkg`:
  - State enum {IDLE, RUN, HALTED}.
  - `PC_INC=4`.
  - Default widths `PC_W`/`INST_W`.
- Sub-module `fetch_fifo`:
  - Parameterised synchronous FIFO of {pc, inst}.
  - Count output and synchronous flush input.
  - Same `clk`/`rst_n`.

## Test plan
- Memory model returns word = address. Reset, then `start`, `out_ready=1` → `out_pc`/`out_inst` = 0x000, 0x004, 0x008… from cycle 3, one per cycle, no gaps.
- Drop `out_ready` for 10 cycles mid-stream:
  - `imem_en` stops with `fifo_count+inflight` ≤ 4.
  - After release the sequence continues with no loss or duplicate.
- `redirect_valid` with `redirect_pc=0x101` while 2 fetches are in flight:
  - Stale words are dropped.
  - Next outputs are 0x100, 0x104.
- Redirect to 0x7FC → outputs 0x7FC, 0x000, 0x004 (wrap).
- `halt` in RUN:
  - `imem_en` is low from the next cycle.
  - Remaining in-flight/FIFO words are delivered, then `busy=0`.
  - `start` resumes at the next sequential PC.
- `rst_n` low for one cycle mid-stream:
  - All outputs hold reset values after the edge.
  - Late `imem_data` is ignored.
  - After `start`, fetching restarts at `RESET_PC`.
